// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: handshake, drain/discard control and occupancy bundle of pipeline_ctrl
interface pipeline_ctrl_if #(
    parameter int NUM_STAGES = 4
);
    logic in_valid, in_ready, out_valid, out_ready, pipe_ce, drain_req, drain_done, discard;
    logic [$clog2(NUM_STAGES + 1)-1:0] occupancy;
    modport master(
        output in_valid, out_ready, drain_req, discard,
        input  in_ready, out_valid, pipe_ce, drain_done, occupancy
    );
    modport slave(
        input  in_valid, out_ready, drain_req, discard,
        output in_ready, out_valid, pipe_ce, drain_done, occupancy
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: valid-vector controller for a CE-gated register pipeline with drain, discard and occupancy
module pipeline_ctrl #(
    parameter int NUM_STAGES = 4
) (
    input logic clk,
    input logic rstn,
    pipeline_ctrl_if.slave bus
);
    localparam int OW = $clog2(NUM_STAGES + 1);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    state_t state, state_next;
    logic [NUM_STAGES-1:0] v, v_next;
    logic [OW-1:0] occ;
    logic done, accept, shift_out;
    assign bus.pipe_ce = (~v[NUM_STAGES-1] | bus.out_ready) & rstn & ~bus.discard & (state != HALT);
    assign bus.in_ready = bus.pipe_ce & (state == RUN);
    assign bus.out_valid = v[NUM_STAGES-1];
    assign bus.occupancy = occ;
    assign bus.drain_done = done;
    assign accept = bus.in_valid & bus.in_ready;
    assign shift_out = bus.pipe_ce & v[NUM_STAGES-1];
    // bubbles shift along with valid items; nothing is ever collapsed
    assign v_next = bus.discard ? '0 : bus.pipe_ce ? (v << 1) | NUM_STAGES'(accept) : v;
    assign state_next = (state == RUN)   ? (bus.drain_req ? DRAIN : RUN)
                      : (state == DRAIN) ? ((v_next == '0) ? HALT : DRAIN)
                      : (bus.drain_req ? HALT : RUN);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v <= '0;
            occ <= '0;
            state <= RUN;
            done <= 1'b0;
        end else begin
            v <= v_next;
            occ <= bus.discard ? '0 : occ + OW'(accept) - OW'(shift_out);
            state <= state_next;
            done <= (state_next == HALT);
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scenario tasks plus a randomized run against a slot-level model of the pipeline
module tb_pipeline_ctrl;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int in_data = 0;
    int checks = 0;
    int failures = 0;
    int dp [N];
    int slot [N];
    bit draining = 0, halted = 0;
    bit exp_ce, exp_ir, m_ov, m_done;
    logic obs_ce, obs_ir;
    int m_occ = 0;
    int got_q [$];
    int exp_q [$];

    pipeline_ctrl_if #(.NUM_STAGES(N)) bus ();
    pipeline_ctrl #(.NUM_STAGES(N)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

    always #5 clk = ~clk;

    // the data registers the controller gates, sharing its reset
    always @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < N; k++) dp[k] <= 0;
        end else if (bus.pipe_ce) begin
            dp[0] <= in_data;
            for (int k = 1; k < N; k++) dp[k] <= dp[k-1];
        end
    end

    task automatic drive(input bit iv, input bit ordy, input bit dreq, input bit disc);
        bus.in_valid = iv;
        bus.out_ready = ordy;
        bus.drain_req = dreq;
        bus.discard = disc;
    endtask

    // one clock: predict from the model, observe the DUT, advance the model
    task automatic step();
        bit last, acc;
        int cnt;
        #1;
        last = slot[N-1] >= 0;
        exp_ce = (!last || bus.out_ready) && rstn && !bus.discard && !halted;
        exp_ir = exp_ce && !draining && !halted;
        acc = bus.in_valid && exp_ir;
        obs_ce = bus.pipe_ce;
        obs_ir = bus.in_ready;
        if (rstn && bus.out_valid && bus.out_ready) got_q.push_back(dp[N-1]);
        if (rstn && last && bus.out_ready) exp_q.push_back(slot[N-1]);
        @(posedge clk);
        if (!rstn) begin
            for (int k = 0; k < N; k++) slot[k] = -1;
            draining = 0;
            halted = 0;
        end else begin
            if (bus.discard) begin
                for (int k = 0; k < N; k++) slot[k] = -1;
            end else if (exp_ce) begin
                for (int k = N - 1; k > 0; k--) slot[k] = slot[k-1];
                slot[0] = acc ? in_data : -1;
            end
            cnt = 0;
            for (int k = 0; k < N; k++) if (slot[k] >= 0) cnt++;
            if (halted) halted = bus.drain_req;
            else if (draining) begin
                if (cnt == 0) begin
                    draining = 0;
                    halted = 1;
                end
            end else if (bus.drain_req) draining = 1;
        end
        m_occ = 0;
        for (int k = 0; k < N; k++) if (slot[k] >= 0) m_occ++;
        m_ov = slot[N-1] >= 0;
        m_done = halted;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 0;
        drive(1, 1, 0, 0);
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (int'(bus.occupancy) !== 0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.drain_done !== 1'b0) begin failures++; $display("FAIL reset_drain_done got=%b exp=0", bus.drain_done); end
        checks++; if (obs_ce !== 1'b0) begin failures++; $display("FAIL reset_pipe_ce got=%b exp=0", obs_ce); end
        checks++; if (obs_ir !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", obs_ir); end
        rstn = 1;
    endtask

    task automatic test_stream();
        int first_acc = -1, first_ov = -1, peak = 0;
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 18; c++) begin
            in_data = c;
            drive(c < 10, 1, 0, 0);
            step();
            if (first_acc < 0 && c < 10 && obs_ir === 1'b1) first_acc = c;
            if (first_ov < 0 && bus.out_valid === 1'b1) first_ov = c;
            if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
            checks++; if (int'(bus.occupancy) !== m_occ) begin failures++; $display("FAIL stream_occ cyc=%0d got=%0d exp=%0d", c, bus.occupancy, m_occ); end
            checks++; if (bus.out_valid !== m_ov) begin failures++; $display("FAIL stream_ov cyc=%0d got=%b exp=%b", c, bus.out_valid, m_ov); end
        end
        checks++; if (first_acc < 0 || first_ov - first_acc !== N - 1) begin failures++; $display("FAIL stream_latency got=%0d exp=%0d", first_ov - first_acc, N - 1); end
        checks++; if (peak !== N) begin failures++; $display("FAIL stream_peak got=%0d exp=%0d", peak, N); end
        checks++; if (got_q.size() !== 10) begin failures++; $display("FAIL stream_count got=%0d exp=10", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 10; i++) begin
            checks++; if (got_q[i] !== i) begin failures++; $display("FAIL stream_data idx=%0d got=%0d exp=%0d", i, got_q[i], i); end
        end
    endtask

    task automatic test_stall();
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < N; c++) begin
            in_data = 20 + c;
            drive(1, 0, 0, 0);
            step();
        end
        checks++; if (int'(bus.occupancy) !== N) begin failures++; $display("FAIL stall_fill got=%0d exp=%0d", bus.occupancy, N); end
        for (int c = 0; c < 5; c++) begin
            in_data = 90;
            drive(1, 0, 0, 0);
            step();
            checks++; if (obs_ce !== 1'b0) begin failures++; $display("FAIL stall_ce cyc=%0d got=%b exp=0", c, obs_ce); end
            checks++; if (obs_ir !== 1'b0) begin failures++; $display("FAIL stall_ir cyc=%0d got=%b exp=0", c, obs_ir); end
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_ov cyc=%0d got=%b exp=1", c, bus.out_valid); end
            checks++; if (int'(bus.occupancy) !== N) begin failures++; $display("FAIL stall_occ cyc=%0d got=%0d exp=%0d", c, bus.occupancy, N); end
        end
        for (int c = 0; c < 8; c++) begin
            drive(0, 1, 0, 0);
            step();
        end
        checks++; if (got_q.size() !== N) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), N); end
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            checks++; if (got_q[i] !== 20 + i) begin failures++; $display("FAIL stall_data idx=%0d got=%0d exp=%0d", i, got_q[i], 20 + i); end
        end
    endtask

    task automatic test_drain();
        int cyc = 0;
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            in_data = 40 + c;
            drive(1, 1, 0, 0);
            step();
        end
        drive(0, 1, 1, 0);
        step();
        while (bus.drain_done !== 1'b1 && cyc < 20) begin
            drive(1, 1, 1, 0);
            step();
            checks++; if (obs_ir !== 1'b0) begin failures++; $display("FAIL drain_ir cyc=%0d got=%b exp=0", cyc, obs_ir); end
            checks++; if (bus.drain_done !== m_done) begin failures++; $display("FAIL drain_done cyc=%0d got=%b exp=%b", cyc, bus.drain_done, m_done); end
            cyc++;
        end
        checks++; if (bus.drain_done !== 1'b1) begin failures++; $display("FAIL drain_timeout got=%b exp=1", bus.drain_done); end
        checks++; if (int'(bus.occupancy) !== 0) begin failures++; $display("FAIL drain_occ got=%0d exp=0", bus.occupancy); end
        checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL drain_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++; if (got_q[i] !== 40 + i) begin failures++; $display("FAIL drain_data idx=%0d got=%0d exp=%0d", i, got_q[i], 40 + i); end
        end
        drive(1, 1, 1, 0);
        step();
        checks++; if (obs_ce !== 1'b0) begin failures++; $display("FAIL halt_ce got=%b exp=0", obs_ce); end
        checks++; if (bus.drain_done !== 1'b1) begin failures++; $display("FAIL halt_hold got=%b exp=1", bus.drain_done); end
        in_data = 50;
        drive(1, 1, 0, 0);
        step();
        checks++; if (obs_ir !== 1'b0) begin failures++; $display("FAIL resume_edge_ir got=%b exp=0", obs_ir); end
        checks++; if (bus.drain_done !== 1'b0) begin failures++; $display("FAIL resume_done got=%b exp=0", bus.drain_done); end
        step();
        checks++; if (obs_ir !== 1'b1) begin failures++; $display("FAIL resume_ir got=%b exp=1", obs_ir); end
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, 0);
            step();
        end
    endtask

    task automatic test_bubbles();
        bit ov_hist [12];
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            in_data = 60 + c;
            drive(c < 8 && c % 2 == 0, 1, 0, 0);
            step();
            ov_hist[c] = bus.out_valid;
            checks++; if (bus.out_valid !== m_ov) begin failures++; $display("FAIL bubble_ov cyc=%0d got=%b exp=%b", c, bus.out_valid, m_ov); end
        end
        for (int c = 0; c < 8; c++) begin
            checks++; if (ov_hist[c + N - 1] !== (c % 2 == 0)) begin failures++; $display("FAIL bubble_pattern cyc=%0d got=%b exp=%b", c + N - 1, ov_hist[c + N - 1], c % 2 == 0); end
        end
        checks++; if (got_q.size() !== 4) begin failures++; $display("FAIL bubble_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== 60 + 2 * i) begin failures++; $display("FAIL bubble_data idx=%0d got=%0d exp=%0d", i, got_q[i], 60 + 2 * i); end
        end
    endtask

    task automatic test_discard();
        bit seen = 0;
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 2; c++) begin
            in_data = 80 + c;
            drive(1, 1, 0, 0);
            step();
        end
        drive(1, 1, 0, 1);
        step();
        checks++; if (obs_ce !== 1'b0) begin failures++; $display("FAIL discard_ce got=%b exp=0", obs_ce); end
        checks++; if (obs_ir !== 1'b0) begin failures++; $display("FAIL discard_ir got=%b exp=0", obs_ir); end
        checks++; if (int'(bus.occupancy) !== 0) begin failures++; $display("FAIL discard_occ got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL discard_ov got=%b exp=0", bus.out_valid); end
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, 0);
            step();
            if (bus.out_valid === 1'b1) seen = 1;
        end
        checks++; if (seen || got_q.size() !== 0) begin failures++; $display("FAIL discard_leak got=%0d items exp=0", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < N; c++) begin
            in_data = 100 + c;
            drive(1, 0, 0, 0);
            step();
        end
        rstn = 0;
        drive(1, 1, 0, 0);
        step();
        rstn = 1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ov got=%b exp=0", bus.out_valid); end
        checks++; if (int'(bus.occupancy) !== 0) begin failures++; $display("FAIL rstmid_occ got=%0d exp=0", bus.occupancy); end
        in_data = 200;
        drive(1, 1, 0, 0);
        step();
        checks++; if (obs_ir !== 1'b1) begin failures++; $display("FAIL rstmid_ir got=%b exp=1", obs_ir); end
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, 0);
            step();
        end
        checks++; if (got_q.size() !== 1 || got_q[0] !== 200) begin failures++; $display("FAIL rstmid_data got=%0d items exp=1 item 200", got_q.size()); end
    endtask

    task automatic test_random();
        bit dreq = 0;
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 800; c++) begin
            rstn = ($urandom_range(0, 99) != 0);
            in_data = int'($urandom_range(0, 65535));
            if ($urandom_range(0, 19) == 0) dreq = !dreq;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, dreq, $urandom_range(0, 29) == 0);
            step();
            checks++; if (obs_ce !== exp_ce) begin failures++; $display("FAIL rnd_ce cyc=%0d got=%b exp=%b", c, obs_ce, exp_ce); end
            checks++; if (obs_ir !== exp_ir) begin failures++; $display("FAIL rnd_ir cyc=%0d got=%b exp=%b", c, obs_ir, exp_ir); end
            checks++; if (bus.out_valid !== m_ov) begin failures++; $display("FAIL rnd_ov cyc=%0d got=%b exp=%b", c, bus.out_valid, m_ov); end
            checks++; if (int'(bus.occupancy) !== m_occ) begin failures++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, bus.occupancy, m_occ); end
            checks++; if (bus.drain_done !== m_done) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", c, bus.drain_done, m_done); end
        end
        rstn = 1;
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_data idx=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) slot[k] = -1;
        drive(0, 0, 0, 0);
        test_reset();
        test_stream();
        test_stall();
        test_drain();
        test_bubbles();
        test_discard();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: PIPELINE_CTRL

Interface
REQ-001 Parameter: NUM_STAGES, default 4, depth of the controlled CE-gated register pipeline; legal range 1..64.
REQ-002 Port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 Port: RSTN  input  1  reset, synchronous, active-low.
REQ-004 Port: IN_VALID  input  1  upstream item present.
REQ-005 Port: IN_READY  output  1  controller accepts upstream item this cycle.
REQ-006 Port: OUT_VALID  output  1  last pipeline stage holds a valid item.
REQ-007 Port: OUT_READY  input  1  downstream accepts item this cycle.
REQ-008 Port: PIPE_CE  output  1  common clock enable for every stage of the controlled pipeline.
REQ-009 Port: DRAIN_REQ  input  1  level request to stop intake and empty the pipeline.
REQ-010 Port: DRAIN_DONE  output  1  high while pipeline is empty and halted.
REQ-011 Port: DISCARD  input  1  single-cycle synchronous invalidation of all in-flight items.
REQ-012 Port: OCCUPANCY  output  $clog2(NUM_STAGES+1)  number of valid items in flight.

Function
REQ-013 Controller SHALL hold a valid vector V[NUM_STAGES-1:0]; V[k] tracks pipeline stage k; stage 0 is the input stage.
REQ-014 OUT_VALID SHALL equal V[NUM_STAGES-1].
REQ-015 PIPE_CE SHALL be combinational: (~V[NUM_STAGES-1] | OUT_READY) & RSTN & ~DISCARD & (state != HALT).
REQ-016 IN_READY SHALL be combinational: PIPE_CE & (state == RUN).
REQ-017 On an edge with PIPE_CE=1: V[0] <= IN_VALID & IN_READY; V[k] <= V[k-1] for k>=1; with PIPE_CE=0 V SHALL hold.
REQ-018 Upstream transfer = IN_VALID & IN_READY; downstream transfer = OUT_VALID & OUT_READY; both may occur in the same cycle.
REQ-019 Throughput SHALL be one item per cycle while OUT_READY=1; latency from accept edge to OUT_VALID SHALL be exactly NUM_STAGES PIPE_CE edges.
REQ-020 Bubbles (V[k]=0) SHALL NOT be collapsed; a stalled last stage (OUT_VALID=1, OUT_READY=0) SHALL freeze all stages.
REQ-021 OCCUPANCY SHALL be a register updated on each edge to popcount of next V; +1 on accept only, -1 on output transfer only, unchanged when both or neither occur.
REQ-022 FSM states: RUN, DRAIN, HALT.
REQ-023 RUN -> DRAIN on edge with DRAIN_REQ=1; the item accepted in that same cycle (if any) SHALL be kept and drained.
REQ-024 In DRAIN, IN_READY=0; PIPE_CE follows REQ-015, so in-flight items continue to drain and V[0] fills with bubbles.
REQ-025 DRAIN -> HALT on edge where next V is all zero; from RUN with empty pipe, RUN -> DRAIN -> HALT takes two edges.
REQ-026 In HALT: PIPE_CE=0, IN_READY=0, DRAIN_DONE=1 (registered, high every HALT cycle, 0 otherwise).
REQ-027 HALT -> RUN on edge with DRAIN_REQ=0; DRAIN_REQ deasserted during DRAIN SHALL NOT abort the drain.
REQ-028 DISCARD=1: PIPE_CE=0, IN_READY=0 that cycle; at the edge V <= 0 and OCCUPANCY <= 0; FSM state unchanged except DRAIN -> HALT.
REQ-029 An output transfer coincident with DISCARD SHALL be considered completed by downstream; no item is replayed.
REQ-030 NUM_STAGES=1 SHALL be supported: V is one bit, behaviour per REQ-015..REQ-028.

Reset
REQ-031 While RSTN=0 at an edge: V=0, OCCUPANCY=0, state=RUN, DRAIN_DONE=0.
REQ-032 While RSTN=0: PIPE_CE=0, IN_READY=0, OUT_VALID=0 after the first reset edge.
REQ-033 Reset mid-operation SHALL drop all in-flight items with no output transfer after the reset edge; controlled pipeline shares RSTN.

Verification
REQ-034 NUM_STAGES=4, OUT_READY=1, IN_VALID=1 for 10 cycles with counting data -> OUT_VALID rises 4 edges after first accept, 10 consecutive in-order items, OCCUPANCY peaks at 4.
REQ-035 Fill 4 items, hold OUT_READY=0 for 5 cycles -> PIPE_CE=0, IN_READY=0, OUT_VALID=1, OCCUPANCY=4 constant; release -> one item per cycle, none lost or duplicated.
REQ-036 3 items in flight, assert DRAIN_REQ -> IN_READY=0 next cycle, all 3 items delivered, DRAIN_DONE=1 once OCCUPANCY=0; deassert DRAIN_REQ -> RUN, IN_READY=1 next cycle.
REQ-037 Alternating IN_VALID (1,0,1,0) with OUT_READY=1 -> bubbles preserved at output, OUT_VALID pattern 1,0,1,0 delayed 4 cycles.
REQ-038 2 items in flight, pulse DISCARD with OUT_READY=1 -> OCCUPANCY=0 and OUT_VALID=0 next cycle, discarded items never appear.
REQ-039 RSTN low for one cycle while 4 items in flight -> OUT_VALID=0, OCCUPANCY=0, state RUN, IN_READY=1 in the first cycle after RSTN returns high.
